// File: rtl/sha256_compress_core.sv
// rtl/sha256_compress_core.sv - iterative SHA-256 block compression engine
module sha256_compress_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [255:0] in_hash,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_hash,
  output logic         busy
);

  // Only power-of-two divisors of 64 keep the last-round test exact
  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("sha256_compress_core: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [5:0] T_LAST = 6'(64 - UNROLL);
  localparam logic [5:0] T_STEP = 6'(UNROLL);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [5:0]   t_q;
  logic [31:0]  w_q  [16];   // W[t] .. W[t+15]
  logic [31:0]  v_q  [8];    // working variables a..h
  logic [31:0]  hs_q [8];    // chaining state saved at accept
  logic [255:0] hash_q;
  logic         out_valid_q;
  logic         accept;

  logic [31:0]  sched [16+UNROLL];
  logic [31:0]  v_d   [8];
  logic [31:0]  w_d   [16];
  logic [31:0]  t1, t2;

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == S_ROUND);
  assign out_valid = out_valid_q;
  assign out_hash  = hash_q;

  // Next-state selection for the accept / round / hand-off sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ROUND;
      S_ROUND: if (t_q == T_LAST) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Chain UNROLL rounds; schedule words made this cycle feed later rounds of the same cycle
  always_comb begin
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 16; i++) sched[i] = w_q[i];
    for (int j = 0; j < UNROLL; j++)
      sched[16+j] = small_sig1(sched[14+j]) + sched[9+j] + small_sig0(sched[1+j]) + sched[j];
    for (int i = 0; i < 8; i++) v_d[i] = v_q[i];
    for (int i = 0; i < UNROLL; i++) begin
      t1 = v_d[7] + big_sig1(v_d[4]) + ((v_d[4] & v_d[5]) ^ (~v_d[4] & v_d[6]))
         + K_ROM[t_q + 6'(i)] + sched[i];
      t2 = big_sig0(v_d[0]) + ((v_d[0] & v_d[1]) ^ (v_d[0] & v_d[2]) ^ (v_d[1] & v_d[2]));
      v_d[7] = v_d[6];
      v_d[6] = v_d[5];
      v_d[5] = v_d[4];
      v_d[4] = v_d[3] + t1;
      v_d[3] = v_d[2];
      v_d[2] = v_d[1];
      v_d[1] = v_d[0];
      v_d[0] = t1 + t2;
    end
    for (int i = 0; i < 16; i++) w_d[i] = sched[i+UNROLL];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Load block at accept, advance rounds, publish and hold the digest until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_q         <= '0;
      hash_q      <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        v_q[i]  <= '0;
        hs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            t_q <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= in_block[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
              v_q[i]  <= in_hash[255-32*i -: 32];
              hs_q[i] <= in_hash[255-32*i -: 32];
            end
          end
        end
        S_ROUND: begin
          t_q <= t_q + T_STEP;
          for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
          for (int i = 0; i < 8; i++) v_q[i] <= v_d[i];
          if (t_q == T_LAST) begin
            out_valid_q <= 1'b1;
            for (int i = 0; i < 8; i++) hash_q[255-32*i -: 32] <= hs_q[i] + v_d[i];
          end
        end
        S_DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_core.sv
// tb/tb_sha256_compress_core.sv - scoreboard bench for sha256_compress_core at UNROLL 1 and 4
module tb_sha256_compress_core;

  localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [511:0] CHAIN1    = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [511:0] CHAIN2    = {480'h0, 32'h000001c0};
  localparam logic [255:0] CHAIN_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [2];
  logic         out_ready [2];
  logic [511:0] in_block  [2];
  logic [255:0] in_hash   [2];
  wire          in_ready  [2];
  wire          out_valid [2];
  wire          busy      [2];
  wire  [255:0] out_hash  [2];

  int n_checks;
  int n_pass;
  logic [255:0] exp_q [$];

  always #5 clk = ~clk;

  sha256_compress_core #(.UNROLL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_block(in_block[0]), .in_hash(in_hash[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_hash(out_hash[0]), .busy(busy[0])
  );

  sha256_compress_core #(.UNROLL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_block(in_block[1]), .in_hash(in_hash[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_hash(out_hash[1]), .busy(busy[1])
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Straight FIPS 180-4 compression with a full 64-word schedule
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, ch, maj, tt1, tt2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      tt1 = v[7] + s1 + ch + K[t] + w[t];
      s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
      maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      tt2 = s0 + maj;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + tt1;
      v[0] = tt1 + tt2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom();
    return h;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a transfer completes on the edge after out_valid && out_ready
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n === 1'b1 && out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
        if (exp_q.size() == 0) check($sformatf("unexpected_output_dut%0d", i), out_hash[i], 256'hx);
        else check($sformatf("digest_dut%0d", i), out_hash[i], exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready(input int d);
    int k;
    k = 0;
    while (in_ready[d] !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check($sformatf("ready_timeout_dut%0d", d), 256'(in_ready[d]), 256'(1));
  endtask

  task automatic send(input int d, input logic [511:0] blk, input logic [255:0] hin,
                      input logic [255:0] req, input bit stall);
    int n, k, busy_cnt;
    n = (d == 0) ? 64 : 16;
    wait_ready(d);
    in_block[d]  = blk;
    in_hash[d]   = hin;
    in_valid[d]  = 1'b1;
    out_ready[d] = !stall;
    exp_q.push_back(req);
    tick();
    in_valid[d] = 1'b0;
    in_block[d] = rand_block();
    in_hash[d]  = rand_hash();
    k = 0;
    busy_cnt = 0;
    while (out_valid[d] !== 1'b1 && k < 200) begin
      if (busy[d] === 1'b1) busy_cnt++;
      tick();
      k++;
    end
    check($sformatf("latency_dut%0d", d), 256'(k), 256'(n));
    check($sformatf("busy_cycles_dut%0d", d), 256'(busy_cnt), 256'(n));
    if (stall) begin
      for (int c = 0; c < 10; c++) begin
        in_valid[d] = 1'($urandom_range(1));
        in_block[d] = rand_block();
        tick();
        check($sformatf("stall_in_ready_dut%0d", d), 256'(in_ready[d]), 256'(0));
        check($sformatf("stall_out_valid_dut%0d", d), 256'(out_valid[d]), 256'(1));
        check($sformatf("stall_out_hash_dut%0d", d), out_hash[d], req);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
    end
    tick();
    check($sformatf("post_xfer_out_valid_dut%0d", d), 256'(out_valid[d]), 256'(0));
    check($sformatf("post_xfer_in_ready_dut%0d", d), 256'(in_ready[d]), 256'(1));
  endtask

  task automatic reset_mid(input int d);
    int cycles;
    cycles = (d == 0) ? 30 : 7;
    wait_ready(d);
    in_block[d] = ABC_BLK;
    in_hash[d]  = IV;
    in_valid[d] = 1'b1;
    tick();
    in_valid[d] = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b0;
    tick();
    check($sformatf("rst_out_valid_dut%0d", d), 256'(out_valid[d]), 256'(0));
    check($sformatf("rst_out_hash_dut%0d", d), out_hash[d], 256'(0));
    check($sformatf("rst_busy_dut%0d", d), 256'(busy[d]), 256'(0));
    check($sformatf("rst_in_ready_low_dut%0d", d), 256'(in_ready[d]), 256'(0));
    rst_n = 1'b1;
    #1;
    check($sformatf("rst_in_ready_high_dut%0d", d), 256'(in_ready[d]), 256'(1));
  endtask

  task automatic run_suite(input int d);
    logic [255:0] mid, hin;
    logic [511:0] blk;
    send(d, ABC_BLK, IV, ABC_DIG, 1'b0);
    send(d, EMPTY_BLK, IV, EMPTY_DIG, 1'b0);
    mid = ref_compress(IV, CHAIN1);
    send(d, CHAIN1, IV, mid, 1'b0);
    send(d, CHAIN2, mid, CHAIN_DIG, 1'b0);
    blk = rand_block();
    hin = rand_hash();
    send(d, blk, hin, ref_compress(hin, blk), 1'b1);
    reset_mid(d);
    send(d, ABC_BLK, IV, ABC_DIG, 1'b0);
    for (int r = 0; r < 3; r++) begin
      blk = rand_block();
      hin = rand_hash();
      send(d, blk, hin, ref_compress(hin, blk), r == 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      in_block[d]  = '0;
      in_hash[d]   = '0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_out_valid_dut%0d", d), 256'(out_valid[d]), 256'(0));
      check($sformatf("reset_out_hash_dut%0d", d), out_hash[d], 256'(0));
      check($sformatf("reset_busy_dut%0d", d), 256'(busy[d]), 256'(0));
      check($sformatf("reset_in_ready_dut%0d", d), 256'(in_ready[d]), 256'(0));
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("release_in_ready_dut%0d", d), 256'(in_ready[d]), 256'(1));
    for (int d = 0; d < 2; d++) run_suite(d);
    repeat (3) tick();
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
